draw_sprite_engine: RTL and testbench
=====================================

Name: draw_sprite_engine

Overview:
- Parametrised rectangle/sprite rasteriser that generates one VGA pixel write per clock for a BLK_W x BLK_H block at (x0, y0).
- Drives the vga_adapter x/y/colour/plot inputs.
- Compared with the fixed 8x8 free-running drawer, it adds a start/busy/done handshake, single-pass drawing, screen-edge clipping and an erase mode.
- Sits between the game logic (player and maze tiles) and the VGA adapter. One instance is used per drawing client, behind an arbiter.

Parameters:
- BLK_W, 8, sprite width in pixels (1..64)
- BLK_H, 8, sprite height in pixels (1..64)
- X_W, 9, x coordinate width
- Y_W, 8, y coordinate width
- COLOR_W, 3, colour width
- SCREEN_W, 320, visible width; pixels at x >= SCREEN_W are clipped
- SCREEN_H, 240, visible height; pixels at y >= SCREEN_H are clipped

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- start  in  1  request a draw; sampled only in IDLE
- erase  in  1  sampled with start; 1 = draw bg_colour instead of colour
- x0  in  X_W  top-left x, sampled with start
- y0  in  Y_W  top-left y, sampled with start
- colour  in  COLOR_W  foreground colour, sampled with start
- bg_colour  in  COLOR_W  erase colour, sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the pass completes
- vga_x  out  X_W  pixel x
- vga_y  out  Y_W  pixel y
- vga_color  out  COLOR_W  pixel colour
- plot  out  1  write strobe; vga_x/vga_y/vga_color valid when high

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE; busy=0, done=0, plot=0; vga_x=0, vga_y=0, vga_color=0; dx=0, dy=0.
- States:
  - IDLE: on start=1 at edge E0, latch x0, y0, the effective colour (erase ? bg_colour : colour) and the mask; clear dx/dy; set busy=1; go to DRAW.
  - DRAW: at each edge, register pixel (dx, dy) to outputs and advance dx, wrapping to 0 and incrementing dy at dx=BLK_W-1. After the pixel (BLK_W-1, BLK_H-1) is registered, go to FIN.
  - FIN: at the next edge, plot=0, done=1, busy=0; return to IDLE.
- Latency:
  - Pixel k (raster index k = dy*BLK_W + dx, dx fastest) appears after edge E(k+1).
  - done appears after edge E(BLK_W*BLK_H+1).
  - Total occupancy is BLK_W*BLK_H+1 cycles after E0.
- Pixel address: vga_x = x0+dx, vga_y = y0+dy.
  - Sums are computed one bit wider (X_W+1, Y_W+1) for the clip test.
  - Outputs take the low bits; no wrap-around pixels are ever plotted.
- Clipping: if sum_x >= SCREEN_W or sum_y >= SCREEN_H, that cycle still elapses but plot=0. Timing is identical whether or not clipping occurs.
- plot is deasserted in IDLE and FIN.
- vga_x/vga_y/vga_color hold their last values when plot=0.
- start while busy (DRAW/FIN) is ignored and not queued.
- Inputs changing during DRAW have no effect; everything is latched at E0.
- start asserted in the FIN cycle is ignored. start held high continuously is accepted again in the cycle after done, which makes back-to-back passes one cycle apart.
- Reset asserted mid-pass aborts immediately to reset values. No done pulse is produced.

Optional Feature:
- Macro: DRAW_SPRITE_MASK_EN.
- When defined:
  - Adds input port mask, width BLK_W*BLK_H, sampled with start.
  - Bit index k = dy*BLK_W + dx.
  - mask[k]=0 makes that pixel transparent (plot=0 for that cycle). Timing is unchanged.
  - Erase also honours the mask.
- When undefined: no mask port exists, and all in-bounds pixels are plotted.

Test Plan:
- Defaults, start with x0=10, y0=20, colour=3'b110 → 64 consecutive plot cycles, first (10,20) and last (17,27), raster order. done one cycle after the last pixel; busy high for 65 cycles.
- x0=316, y0=236 → 16 plots total (x 316..319, y 236..239); still 65 busy cycles; no plot with x >= 320 or y >= 240.
- erase=1, bg_colour=3'b000, colour=3'b111 → every plotted pixel has vga_color=0.
- start re-pulsed and x0 changed mid-pass → ignored; pixels still from the original x0; exactly one done. start held high → second pass begins the cycle after done.
- resetn dropped at pixel 30 → plot, busy and done are 0 immediately (asynchronously), with no done pulse; a new start after release draws a full pass.
- DRAW_SPRITE_MASK_EN defined, mask=64'h00000000000000FF → plot only for row dy=0 (8 pixels); done timing unchanged.

Source files
------------

// File: rtl/draw_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : draw_sprite_engine
// Brief    : Single-pass BLK_W x BLK_H sprite rasteriser with screen clipping
//            and erase mode; one VGA pixel write per clock. Defining
//            DRAW_SPRITE_MASK_EN adds a per-pixel transparency mask.
// Revision : 1.0
// ============================================================================
module draw_sprite_engine #(
    parameter int BLK_W    = 8,
    parameter int BLK_H    = 8,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   erase,
    input  logic [X_W-1:0]         x0,
    input  logic [Y_W-1:0]         y0,
    input  logic [COLOR_W-1:0]     colour,
    input  logic [COLOR_W-1:0]     bg_colour,
`ifdef DRAW_SPRITE_MASK_EN
    input  logic [BLK_W*BLK_H-1:0] mask,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [COLOR_W-1:0]     vga_color,
    output logic                   plot
);

    localparam int DX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int DY_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam logic [DX_W-1:0] DX_LAST = DX_W'(BLK_W - 1);
    localparam logic [DY_W-1:0] DY_LAST = DY_W'(BLK_H - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [X_W-1:0]       x0_q, x0_d;
    logic [Y_W-1:0]       y0_q, y0_d;
    logic [COLOR_W-1:0]   col_q, col_d;
    logic [DX_W-1:0]      dx_q, dx_d;
    logic [DY_W-1:0]      dy_q, dy_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 plot_q, plot_d;
    logic [X_W-1:0]       vx_q, vx_d;
    logic [Y_W-1:0]       vy_q, vy_d;
    logic [COLOR_W-1:0]   vc_q, vc_d;
    logic [X_W:0]         sum_x;
    logic [Y_W:0]         sum_y;
    logic                 in_bounds;
    logic                 pix_en;

    // One extra bit keeps the clip test honest: wrapped addresses never plot.
    assign sum_x     = {1'b0, x0_q} + (X_W+1)'(dx_q);
    assign sum_y     = {1'b0, y0_q} + (Y_W+1)'(dy_q);
    assign in_bounds = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

`ifdef DRAW_SPRITE_MASK_EN
    // Mask shifts right once per pixel, so bit 0 always belongs to (dx, dy).
    logic [BLK_W*BLK_H-1:0] mask_q, mask_d;
    assign pix_en = mask_q[0];
`else
    assign pix_en = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        col_d   = col_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        plot_d  = 1'b0;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
`ifdef DRAW_SPRITE_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    col_d   = erase ? bg_colour : colour;
                    dx_d    = '0;
                    dy_d    = '0;
                    busy_d  = 1'b1;
                    state_d = S_DRAW;
`ifdef DRAW_SPRITE_MASK_EN
                    mask_d  = mask;
`endif
                end
            end
            S_DRAW: begin
                if (in_bounds && pix_en) begin
                    plot_d = 1'b1;
                    vx_d   = sum_x[X_W-1:0];
                    vy_d   = sum_y[Y_W-1:0];
                    vc_d   = col_q;
                end
`ifdef DRAW_SPRITE_MASK_EN
                mask_d = mask_q >> 1;
`endif
                if (dx_q == DX_LAST) begin
                    dx_d = '0;
                    if (dy_q == DY_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        dy_d = dy_q + DY_W'(1);
                    end
                end else begin
                    dx_d = dx_q + DX_W'(1);
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            col_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            plot_q  <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
`ifdef DRAW_SPRITE_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            col_q   <= col_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
`ifdef DRAW_SPRITE_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign plot      = plot_q;
    assign vga_x     = vx_q;
    assign vga_y     = vy_q;
    assign vga_color = vc_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_sprite_engine
// Brief    : Self-checking bench for draw_sprite_engine against a raster-order
//            reference model; honours DRAW_SPRITE_MASK_EN when defined.
// Revision : 1.0
// ============================================================================
module tb_draw_sprite_engine;

    localparam int BW = 8;
    localparam int BH = 8;
    localparam int NPIX = BW * BH;
    localparam int SW = 320;
    localparam int SH = 240;

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic            start = 1'b0;
    logic            erase = 1'b0;
    logic [8:0]      x0 = '0;
    logic [7:0]      y0 = '0;
    logic [2:0]      colour = '0;
    logic [2:0]      bg_colour = '0;
    logic [NPIX-1:0] mask = '1;
    logic            busy, done, plot;
    logic [8:0]      vga_x;
    logic [7:0]      vga_y;
    logic [2:0]      vga_color;

    int n_checks = 0;
    int n_pass = 0;

    // Reference state: last plotted pixel (outputs hold it when plot is low).
    int m_x = 0, m_y = 0, m_c = 0;
    logic [NPIX-1:0] m_mask;

    draw_sprite_engine dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .erase     (erase),
        .x0        (x0),
        .y0        (y0),
        .colour    (colour),
        .bg_colour (bg_colour),
`ifdef DRAW_SPRITE_MASK_EN
        .mask      (mask),
`endif
        .busy      (busy),
        .done      (done),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .plot      (plot)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outs(input string tag, input int e_plot, input int e_busy, input int e_done);
        check({tag, ".plot"}, 32'(plot), 32'(e_plot));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".x"}, 32'(vga_x), 32'(m_x));
        check({tag, ".y"}, 32'(vga_y), 32'(m_y));
        check({tag, ".col"}, 32'(vga_color), 32'(m_c));
    endtask

    task automatic scramble_inputs();
        x0        = 9'($urandom);
        y0        = 8'($urandom);
        colour    = 3'($urandom);
        bg_colour = 3'($urandom);
        erase     = 1'($urandom);
        mask      = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            start = 1'b0;
            scramble_inputs();
            @(posedge clock); #1;
            check_outs("idle", 0, 0, 0);
        end
    endtask

    // mode: 0 = start low during pass, 1 = random start re-pulses, 2 = start held high.
    // abort_at > 0 drops resetn just after pixel cycle abort_at is checked.
    task automatic run_pass(input int xs, input int ys, input int col, input int bg,
                            input int er, input logic [NPIX-1:0] mk,
                            input int mode, input int abort_at);
        int eff;
        @(negedge clock);
        start = 1'b1; x0 = 9'(xs); y0 = 8'(ys);
        colour = 3'(col); bg_colour = 3'(bg); erase = 1'(er); mask = mk;
`ifdef DRAW_SPRITE_MASK_EN
        m_mask = mk;
`else
        m_mask = '1;
`endif
        eff = (er != 0) ? bg : col;
        @(posedge clock); #1;
        check_outs("accept", 0, 1, 0);
        for (int c = 1; c <= NPIX + 1; c++) begin
            @(negedge clock);
            start = (mode == 0) ? 1'b0 : (mode == 1) ? 1'($urandom) : 1'b1;
            scramble_inputs();
            @(posedge clock); #1;
            if (c <= NPIX) begin
                int k, sx, sy, ep;
                k  = c - 1;
                sx = xs + (k % BW);
                sy = ys + (k / BW);
                ep = (sx < SW && sy < SH && m_mask[k]) ? 1 : 0;
                if (ep != 0) begin
                    m_x = sx; m_y = sy; m_c = eff;
                end
                check_outs($sformatf("pix%0d", k), ep, 1, 0);
            end else begin
                check_outs("fin", 0, 0, 1);
            end
            if (c == abort_at) begin
                #2 resetn = 1'b0;
                #1;
                m_x = 0; m_y = 0; m_c = 0;
                check_outs("async_rst", 0, 0, 0);
                @(negedge clock);
                start = 1'b0;
                resetn = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        m_mask = '1;
        #12;
        check_outs("reset", 0, 0, 0);
        @(negedge clock);
        resetn = 1'b1;
        idle(2);

        // Basic pass, then clipping at the bottom-right corner.
        run_pass(10, 20, 3'b110, 3'b001, 0, '1, 0, 0);
        idle(2);
        run_pass(316, 236, 3'b101, 3'b010, 0, '1, 0, 0);
        idle(1);
        // Erase draws the background colour.
        run_pass(100, 50, 3'b111, 3'b000, 1, '1, 0, 0);
        idle(1);
        // Re-pulsed start and changing inputs mid-pass are ignored.
        run_pass(40, 60, 3'b011, 3'b100, 0, '1, 1, 0);
        idle(1);
        // Start held high: second pass accepted the cycle after done.
        run_pass(200, 100, 3'b010, 3'b001, 0, '1, 2, 0);
        run_pass(205, 105, 3'b001, 3'b110, 0, '1, 2, 0);
        idle(1);
        // Reset mid-pass at pixel 30, then a full pass.
        run_pass(30, 30, 3'b100, 3'b011, 0, '1, 0, 31);
        idle(2);
        run_pass(31, 32, 3'b110, 3'b011, 0, '1, 0, 0);
        idle(1);
        // Mask keeping only row 0 (full pass when the mask port is absent).
        run_pass(50, 70, 3'b101, 3'b000, 0, 64'h00000000000000FF, 0, 0);
        idle(1);
        // Wrap-around address: x0+dx overflows X_W bits and must be clipped.
        run_pass(508, 250, 3'b111, 3'b000, 0, '1, 0, 0);
        idle(1);

        for (int r = 0; r < 12; r++) begin
            int xs, ys;
            xs = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 511) : $urandom_range(305, 325);
            ys = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(228, 245);
            run_pass(xs, ys, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1), {$urandom, $urandom}, $urandom_range(0, 2), 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
